// File: rtl/onn_phase_sequencer.sv
// Oscillatory-network phase sequencer: serial phase load, period counter,
// oscillator drive and per-period phase re-measurement with settle/timeout detection.
module onn_phase_sequencer #(
    parameter int unsigned N              = 16,
    parameter int unsigned PW             = 4,
    parameter int unsigned STABLE_PERIODS = 3,
    parameter int unsigned MAX_PERIODS    = 255,
    parameter int unsigned CW             = 8
) (
    input  logic              sclk,
    input  logic              re,
    input  logic              data_in,
    input  logic              load,
    input  logic              start,
    input  logic [N-1:0]      nin,
    output logic [N*PW-1:0]   phi_out,
    output logic [N-1:0]      nout,
    output logic              phi_to_no,
    output logic              busy,
    output logic              settled,
    output logic              timeout,
    output logic [CW-1:0]     period_cnt
);

    localparam int unsigned PHW = N * PW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [PW-1:0] TICK_LAST  = '1;
    localparam logic [CW-1:0] STABLE_LIM = CW'(STABLE_PERIODS);
    localparam logic [CW-1:0] MAX_LIM    = CW'(MAX_PERIODS);

    // Neuron 0 sits at index 0, which is the most significant slot of phi_q.
    logic [1:0]                 state_q, state_d;
    logic [0:N-1][PW-1:0]       phi_q, phi_d;
    logic [N-1:0][PW-1:0]       cap_q, cap_d;
    logic [N-1:0]               seen_q, seen_d;
    logic [N-1:0]               nin_q;
    logic [PW-1:0]              tick_q, tick_d;
    logic [CW-1:0]              pcnt_q, pcnt_d;
    logic [CW-1:0]              stable_q, stable_d;
    logic                       settled_q, settled_d;
    logic                       timeout_q, timeout_d;

    logic [N-1:0]               rise;
    logic                       last_tick;
    logic                       in_run;
    logic [0:N-1][PW-1:0]       new_phi;
    logic                       changed;
    logic [N-1:0]               osc;

    assign rise      = nin & ~nin_q;
    assign in_run    = (state_q == S_RUN);
    assign last_tick = (tick_q == TICK_LAST);

    // Oscillator is high for the first half-period after its phase point.
    always_comb begin
        logic [PW-1:0] d;
        osc = '0;
        d   = '0;
        for (int i = 0; i < N; i++) begin
            d      = tick_q - phi_q[i];
            osc[i] = ~d[PW-1];
        end
    end

    // Phase measured this period: first captured edge, else an edge on the last tick, else hold.
    always_comb begin
        logic [PW-1:0] nv;
        new_phi = phi_q;
        changed = 1'b0;
        nv      = '0;
        for (int i = 0; i < N; i++) begin
            if (seen_q[i]) begin
                nv = cap_q[i];
            end else if (rise[i]) begin
                nv = tick_q;
            end else begin
                nv = phi_q[i];
            end
            new_phi[i] = nv;
            if (nv != phi_q[i]) begin
                changed = 1'b1;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        phi_d     = phi_q;
        cap_d     = cap_q;
        seen_d    = seen_q;
        tick_d    = tick_q;
        pcnt_d    = pcnt_q;
        stable_d  = stable_q;
        settled_d = settled_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (load) begin
                    state_d = S_LOAD;
                    phi_d   = PHW'({phi_q, data_in});
                end else if (start) begin
                    state_d   = S_RUN;
                    tick_d    = '0;
                    pcnt_d    = '0;
                    stable_d  = '0;
                    seen_d    = '0;
                    settled_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (load) begin
                    phi_d = PHW'({phi_q, data_in});
                end else begin
                    state_d   = S_IDLE;
                    settled_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                tick_d = tick_q + PW'(1);
                for (int i = 0; i < N; i++) begin
                    if (rise[i] && !seen_q[i]) begin
                        cap_d[i]  = tick_q;
                        seen_d[i] = 1'b1;
                    end
                end
                if (last_tick) begin
                    phi_d    = new_phi;
                    pcnt_d   = pcnt_q + CW'(1);
                    stable_d = changed ? '0 : stable_q + CW'(1);
                    seen_d   = '0;
                    if (!changed && ((stable_q + CW'(1)) == STABLE_LIM)) begin
                        state_d   = S_DONE;
                        settled_d = 1'b1;
                    end else if ((pcnt_q + CW'(1)) == MAX_LIM) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sclk) begin
        if (re) begin
            state_q   <= S_IDLE;
            phi_q     <= '0;
            cap_q     <= '0;
            seen_q    <= '0;
            nin_q     <= '0;
            tick_q    <= '0;
            pcnt_q    <= '0;
            stable_q  <= '0;
            settled_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phi_q     <= phi_d;
            cap_q     <= cap_d;
            seen_q    <= seen_d;
            nin_q     <= nin;
            tick_q    <= tick_d;
            pcnt_q    <= pcnt_d;
            stable_q  <= stable_d;
            settled_q <= settled_d;
            timeout_q <= timeout_d;
        end
    end

    assign phi_out    = phi_q;
    assign nout       = in_run ? osc : '0;
    assign phi_to_no  = in_run & last_tick;
    assign busy       = in_run;
    assign settled    = settled_q;
    assign timeout    = timeout_q;
    assign period_cnt = pcnt_q;

endmodule

// File: tb/tb_onn_phase_sequencer.sv
// Self-checking bench for onn_phase_sequencer (N=4, PW=3, settle after 3, timeout at 5).
module tb_onn_phase_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 3;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [11:0] phi;
        logic [7:0]  pc;
    } exp_t;

    logic           sclk = 1'b0;
    logic           re, data_in, load, start;
    logic [N-1:0]   nin, nout, sel, drv;
    logic [11:0]    phi_out;
    logic           phi_to_no, busy, settled, timeout;
    logic [CW-1:0]  period_cnt;

    logic [7:0]     sched [N];
    exp_t           q [$];
    int             n_cmp = 0;
    int             n_err = 0;

    // Unselected neurons see their own oscillator; selected ones follow the bench schedule.
    assign nin = (nout & ~sel) | (drv & sel);

    onn_phase_sequencer #(
        .N(N), .PW(PW), .STABLE_PERIODS(3), .MAX_PERIODS(5), .CW(CW)
    ) dut (
        .sclk(sclk), .re(re), .data_in(data_in), .load(load), .start(start),
        .nin(nin), .phi_out(phi_out), .nout(nout), .phi_to_no(phi_to_no),
        .busy(busy), .settled(settled), .timeout(timeout), .period_cnt(period_cnt)
    );

    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic load_word(input logic [11:0] w);
        for (int b = 11; b >= 0; b--) begin
            load    = 1'b1;
            data_in = w[b];
            step();
        end
        load    = 1'b0;
        data_in = 1'b0;
        step();
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drives one full period from tick 0, recording phi_to_no and busy per tick.
    task automatic drive_period(output logic [7:0] p2n, output logic [7:0] bz);
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) drv[i] = sched[i][t];
            p2n[t] = phi_to_no;
            bz[t]  = busy;
            step();
        end
        drv = '0;
    endtask

    task automatic test_reset();
        re = 1'b1; load = 1'b0; start = 1'b0; data_in = 1'b0; sel = '0; drv = '0;
        for (int i = 0; i < N; i++) sched[i] = 8'h00;
        step(); step();
        re = 1'b0;
        n_cmp++;
        if ({phi_out, nout, phi_to_no, busy, settled, timeout, period_cnt} !== 28'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {phi_out, nout, phi_to_no, busy, settled, timeout, period_cnt});
        end
    endtask

    task automatic test_load();
        load = 1'b1; data_in = 1'b1;
        step(); step();
        load_word(12'h146);
        n_cmp++;
        if (phi_out !== 12'h146) begin
            n_err++; $display("FAIL load_phi: got %h expected 146", phi_out);
        end
        step();
        n_cmp++;
        if ({phi_out, busy, settled, timeout} !== {12'h146, 3'b000}) begin
            n_err++; $display("FAIL load_idle_hold: got %h/%b%b%b expected 146/000",
                              phi_out, busy, settled, timeout);
        end
    endtask

    task automatic test_zero_coupling();
        logic [7:0] p2n, bz;
        exp_t e;
        load_word(12'h054);
        sel = '0; drv = '0;
        start_run();
        n_cmp++;
        if ({nout, busy, period_cnt} !== {4'b0001, 1'b1, 8'd0}) begin
            n_err++; $display("FAIL zc_entry: got %b/%b/%0d expected 0001/1/0", nout, busy, period_cnt);
        end
        for (int p = 1; p <= 3; p++) q.push_back('{phi: 12'h054, pc: 8'(p)});
        for (int p = 1; p <= 3; p++) begin
            drive_period(p2n, bz);
            e = q.pop_front();
            n_cmp++;
            if ({phi_out, period_cnt} !== e) begin
                n_err++; $display("FAIL zc_period%0d: got %h/%0d expected %h/%0d",
                                  p, phi_out, period_cnt, e.phi, e.pc);
            end
            if (p == 1) begin
                n_cmp++;
                if ({p2n, bz} !== {8'h80, 8'hFF}) begin
                    n_err++; $display("FAIL zc_pulse: got %b/%b expected 10000000/11111111", p2n, bz);
                end
            end
        end
        n_cmp++;
        if ({settled, timeout, busy, period_cnt} !== {3'b100, 8'd3}) begin
            n_err++; $display("FAIL zc_settle: got %b%b%b/%0d expected 100/3",
                              settled, timeout, busy, period_cnt);
        end
    endtask

    task automatic test_load_start_in_done();
        logic [11:0] w;
        w = 12'hE53;
        load = 1'b1; start = 1'b1; data_in = w[11];
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL load_priority: got busy=%b expected 0", busy);
        end
        for (int b = 10; b >= 0; b--) begin
            data_in = w[b];
            step();
        end
        load = 1'b0; start = 1'b0; data_in = 1'b0;
        step();
        n_cmp++;
        if ({phi_out, settled, timeout, busy} !== {12'hE53, 3'b000}) begin
            n_err++; $display("FAIL load_exit_flags: got %h/%b%b%b expected e53/000",
                              phi_out, settled, timeout, busy);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] p2n, bz;
        exp_t e;
        sel = 4'b0001; drv = '0;
        start_run();
        for (int k = 0; k < 5; k++)
            q.push_back('{phi: {3'(k), 3'd1, 3'd2, 3'd3}, pc: 8'(k + 1)});
        for (int k = 0; k < 5; k++) begin
            sched[0] = 8'd1 << k;
            drive_period(p2n, bz);
            e = q.pop_front();
            n_cmp++;
            if ({phi_out, period_cnt} !== e) begin
                n_err++; $display("FAIL to_period%0d: got %h/%0d expected %h/%0d",
                                  k, phi_out, period_cnt, e.phi, e.pc);
            end
        end
        n_cmp++;
        if ({timeout, settled, busy, period_cnt, phi_out[11:9]} !== {3'b100, 8'd5, 3'd4}) begin
            n_err++; $display("FAIL to_final: got %b%b%b/%0d/%0d expected 100/5/4",
                              timeout, settled, busy, period_cnt, phi_out[11:9]);
        end
        sched[0] = 8'h00; sel = '0;
    endtask

    task automatic test_edge_at_last_tick();
        logic [7:0] p2n, bz;
        exp_t e;
        sel = 4'b0100; drv = '0; sched[2] = 8'h80;
        start_run();
        n_cmp++;
        if ({busy, timeout, period_cnt} !== {2'b10, 8'd0}) begin
            n_err++; $display("FAIL resume_entry: got %b%b/%0d expected 10/0", busy, timeout, period_cnt);
        end
        q.push_back('{phi: 12'h87B, pc: 8'd1});
        for (int p = 2; p <= 4; p++) q.push_back('{phi: 12'h87B, pc: 8'(p)});
        for (int p = 1; p <= 4; p++) begin
            drive_period(p2n, bz);
            sel = '0;
            e = q.pop_front();
            n_cmp++;
            if ({phi_out, period_cnt} !== e) begin
                n_err++; $display("FAIL last_tick_period%0d: got %h/%0d expected %h/%0d",
                                  p, phi_out, period_cnt, e.phi, e.pc);
            end
        end
        n_cmp++;
        if ({settled, timeout, busy, period_cnt} !== {3'b100, 8'd4}) begin
            n_err++; $display("FAIL stable_restart: got %b%b%b/%0d expected 100/4",
                              settled, timeout, busy, period_cnt);
        end
    endtask

    task automatic test_multi_edge();
        logic [7:0] p2n, bz;
        exp_t e;
        sel = 4'b1100; drv = '0; sched[2] = 8'h80; sched[3] = 8'b0000_1010;
        start_run();
        for (int p = 1; p <= 4; p++) q.push_back('{phi: 12'h879, pc: 8'(p)});
        for (int p = 1; p <= 4; p++) begin
            drive_period(p2n, bz);
            sel = 4'b0100;
            e = q.pop_front();
            n_cmp++;
            if ({phi_out, period_cnt} !== e) begin
                n_err++; $display("FAIL multi_edge_period%0d: got %h/%0d expected %h/%0d",
                                  p, phi_out, period_cnt, e.phi, e.pc);
            end
        end
        n_cmp++;
        if ({settled, timeout, busy} !== 3'b100) begin
            n_err++; $display("FAIL multi_edge_settle: got %b%b%b expected 100", settled, timeout, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] p2n, bz;
        exp_t e;
        sel = 4'b0100; drv = '0; sched[2] = 8'h80;
        start_run();
        q.push_back('{phi: 12'h879, pc: 8'd1});
        drive_period(p2n, bz);
        e = q.pop_front();
        n_cmp++;
        if ({phi_out, period_cnt} !== e) begin
            n_err++; $display("FAIL pre_reset_period: got %h/%0d expected %h/%0d",
                              phi_out, period_cnt, e.phi, e.pc);
        end
        for (int t = 0; t < 5; t++) begin
            drv[2] = sched[2][t];
            step();
        end
        re = 1'b1; load = 1'b1; start = 1'b1;
        step();
        re = 1'b0; load = 1'b0; start = 1'b0;
        n_cmp++;
        if ({phi_out, nout, phi_to_no, busy, settled, timeout, period_cnt} !== 28'h0) begin
            n_err++; $display("FAIL mid_run_reset: got %h expected 0",
                              {phi_out, nout, phi_to_no, busy, settled, timeout, period_cnt});
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: got busy=%b expected 0", busy);
        end
        sel = '0; drv = '0;
        start_run();
        n_cmp++;
        if (nout !== 4'hF) begin
            n_err++; $display("FAIL in_phase: got nout=%b expected 1111", nout);
        end
        for (int p = 1; p <= 3; p++) q.push_back('{phi: 12'h000, pc: 8'(p)});
        for (int p = 1; p <= 3; p++) begin
            drive_period(p2n, bz);
            e = q.pop_front();
            n_cmp++;
            if ({phi_out, period_cnt} !== e) begin
                n_err++; $display("FAIL zero_phase_period%0d: got %h/%0d expected %h/%0d",
                                  p, phi_out, period_cnt, e.phi, e.pc);
            end
        end
        n_cmp++;
        if ({settled, timeout, busy} !== 3'b100) begin
            n_err++; $display("FAIL zero_phase_settle: got %b%b%b expected 100", settled, timeout, busy);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_zero_coupling();
        test_load_start_in_done();
        test_timeout();
        test_edge_at_last_tick();
        test_multi_edge();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
